// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: a Moore FSM that steps each instruction through
// fetch/decode/execute/memory/writeback and decodes datapath controls from the state.
module mc_controller #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_r;
  state_t     next_state_s;

  logic       iord_s;
  logic       memwrite_s;
  logic       irwrite_s;
  logic       regdst_s;
  logic       memtoreg_s;
  logic       regwrite_s;
  logic       alusrca_s;
  logic [1:0] alusrcb_s;
  logic [1:0] pcsrc_s;
  logic       pcwrite_s;
  logic       branch_s;
  logic [2:0] alucontrol_s;
  logic       illegal_s;

  // Unknown funct codes fall back to add so the R-type still completes.
  function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
    logic [2:0] alu;
    case (f)
      6'b100000: alu = ALU_ADD;
      6'b100010: alu = ALU_SUB;
      6'b100100: alu = ALU_AND;
      6'b100101: alu = ALU_OR;
      6'b101010: alu = ALU_SLT;
      default:   alu = ALU_ADD;
    endcase
    return alu;
  endfunction

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = FETCH;
    case (state_r)
      FETCH: next_state_s = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state_s = MEMADR;
          OP_RTYPE:     next_state_s = RTYPEEX;
          OP_BEQ:       next_state_s = BEQEX;
          OP_ADDI:      next_state_s = ADDIEX;
          OP_J:         next_state_s = JEX;
          default:      next_state_s = ILLEGAL_TRAP ? HALT : FETCH;
        endcase
      end
      MEMADR: begin
        if (op == OP_LW) begin
          next_state_s = MEMRD;
        end else begin
          next_state_s = MEMWR;
        end
      end
      MEMRD:   next_state_s = MEMWB;
      RTYPEEX: next_state_s = RTYPEWB;
      ADDIEX:  next_state_s = ADDIWB;
      MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX: next_state_s = FETCH;
      HALT:    next_state_s = HALT;
      default: next_state_s = FETCH;
    endcase
  end

  // Moore output decode of the current state.
  always_comb begin
    iord_s       = 1'b0;
    memwrite_s   = 1'b0;
    irwrite_s    = 1'b0;
    regdst_s     = 1'b0;
    memtoreg_s   = 1'b0;
    regwrite_s   = 1'b0;
    alusrca_s    = 1'b0;
    alusrcb_s    = 2'b00;
    pcsrc_s      = 2'b00;
    pcwrite_s    = 1'b0;
    branch_s     = 1'b0;
    alucontrol_s = ALU_ADD;
    illegal_s    = 1'b0;
    case (state_r)
      FETCH: begin
        alusrcb_s = 2'b01;
        irwrite_s = 1'b1;
        pcwrite_s = 1'b1;
      end
      DECODE: begin
        alusrcb_s = 2'b11;
      end
      MEMADR, ADDIEX: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
      end
      MEMRD: begin
        iord_s = 1'b1;
      end
      MEMWB: begin
        memtoreg_s = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
      end
      RTYPEEX: begin
        alusrca_s    = 1'b1;
        alucontrol_s = funct_to_alu(funct);
      end
      RTYPEWB: begin
        regdst_s   = 1'b1;
        regwrite_s = 1'b1;
      end
      BEQEX: begin
        alusrca_s    = 1'b1;
        alucontrol_s = ALU_SUB;
        pcsrc_s      = 2'b01;
        branch_s     = 1'b1;
      end
      ADDIWB: begin
        regwrite_s = 1'b1;
      end
      JEX: begin
        pcsrc_s   = 2'b10;
        pcwrite_s = 1'b1;
      end
      HALT: begin
        illegal_s = 1'b1;
      end
      default: begin
        illegal_s = 1'b0;
      end
    endcase
  end

  // Architectural write enables are suppressed while reset is held.
  assign pcen       = ~reset & (pcwrite_s | (branch_s & zero));
  assign memwrite   = ~reset & memwrite_s;
  assign irwrite    = ~reset & irwrite_s;
  assign regwrite   = ~reset & regwrite_s;

  assign iord       = iord_s;
  assign regdst     = regdst_s;
  assign memtoreg   = memtoreg_s;
  assign alusrca    = alusrca_s;
  assign alusrcb    = alusrcb_s;
  assign pcsrc      = pcsrc_s;
  assign alucontrol = alucontrol_s;
  assign illegal    = illegal_s;
  assign state      = state_r;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: two instances (trap off/on) share stimulus and
// are compared every cycle against a per-instruction state path and the control table.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;

  logic       iord       [2];
  logic       memwrite   [2];
  logic       irwrite    [2];
  logic       regdst     [2];
  logic       memtoreg   [2];
  logic       regwrite   [2];
  logic       alusrca    [2];
  logic [1:0] alusrcb    [2];
  logic [1:0] pcsrc      [2];
  logic       pcen       [2];
  logic [2:0] alucontrol [2];
  logic       illegal    [2];
  logic [3:0] state      [2];

  int n_checks = 0;
  int n_fail   = 0;
  bit halted   = 1'b0;

  always #5 clk = ~clk;

  mc_controller #(.ILLEGAL_TRAP(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord[0]), .memwrite(memwrite[0]), .irwrite(irwrite[0]), .regdst(regdst[0]),
    .memtoreg(memtoreg[0]), .regwrite(regwrite[0]), .alusrca(alusrca[0]),
    .alusrcb(alusrcb[0]), .pcsrc(pcsrc[0]), .pcen(pcen[0]), .alucontrol(alucontrol[0]),
    .illegal(illegal[0]), .state(state[0])
  );

  mc_controller #(.ILLEGAL_TRAP(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord[1]), .memwrite(memwrite[1]), .irwrite(irwrite[1]), .regdst(regdst[1]),
    .memtoreg(memtoreg[1]), .regwrite(regwrite[1]), .alusrca(alusrca[1]),
    .alusrcb(alusrcb[1]), .pcsrc(pcsrc[1]), .pcen(pcen[1]), .alucontrol(alucontrol[1]),
    .illegal(illegal[1]), .state(state[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    logic [5:0] codes [5];
    logic [2:0] alus  [5];
    codes = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    alus  = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};
    for (int i = 0; i < 5; i++) begin
      if (codes[i] == fn) return alus[i];
    end
    return 3'b010;
  endfunction

  function automatic bit is_legal(input logic [5:0] o);
    return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
           (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
  endfunction

  // State visited at a given cycle of an instruction (trap disabled); -1 when done.
  function automatic int path_state(input logic [5:0] o, input int step);
    int p[$];
    case (o)
      6'b100011: p = {0, 1, 2, 3, 4};
      6'b101011: p = {0, 1, 2, 5};
      6'b000000: p = {0, 1, 6, 7};
      6'b000100: p = {0, 1, 8};
      6'b001000: p = {0, 1, 9, 10};
      6'b000010: p = {0, 1, 11};
      default:   p = {0, 1};
    endcase
    return (step < p.size()) ? p[step] : -1;
  endfunction

  // Expected control word {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,pcen,alucontrol,illegal}.
  function automatic logic [15:0] exp_ctrl(input int st, input logic [5:0] fn, input logic z, input logic rst);
    logic io = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, asa = 0, pcw = 0, br = 0, ill = 0, pe;
    logic [1:0] asb = 2'b00, pcs = 2'b00;
    logic [2:0] alu = 3'b010;
    case (st)
      0:  begin asb = 2'b01; irw = 1; pcw = 1; end
      1:  asb = 2'b11;
      2, 9: begin asa = 1; asb = 2'b10; end
      3:  io = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin asa = 1; alu = alu_of(fn); end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; alu = 3'b110; pcs = 2'b01; br = 1; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcw = 1; end
      12: ill = 1;
      default: ill = 0;
    endcase
    pe = pcw | (br & z);
    if (rst) begin
      mw = 0; irw = 0; rw = 0; pe = 0;
    end
    return {io, mw, irw, rd, m2r, rw, asa, asb, pcs, pe, alu, ill};
  endfunction

  task automatic check_dut(input int d, input int st, input logic rst);
    logic [15:0] obs;
    obs = {iord[d], memwrite[d], irwrite[d], regdst[d], memtoreg[d], regwrite[d], alusrca[d],
           alusrcb[d], pcsrc[d], pcen[d], alucontrol[d], illegal[d]};
    check_eq($sformatf("dut%0d_state", d), {28'd0, state[d]}, st);
    check_eq($sformatf("dut%0d_ctrl_st%0d_rst%0d", d, st, rst), {16'd0, obs},
             {16'd0, exp_ctrl(st, funct, zero, rst)});
  endtask

  // zmode: 0/1 force zero, 2 random; rst_at: cycle index at which reset is pulsed, -1 none.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] fn, input int zmode, input int rst_at);
    op    = o;
    funct = fn;
    for (int step = 0; path_state(o, step) >= 0; step++) begin
      int st;
      logic r;
      st    = path_state(o, step);
      r     = (step == rst_at);
      reset = r;
      zero  = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      @(negedge clk);
      check_dut(0, st, r);
      check_dut(1, halted ? 12 : st, r);
      @(posedge clk);
      #1;
      if (r) begin
        halted = 1'b0;
        reset  = 1'b0;
        return;
      end
      if (st == 1 && !is_legal(o)) halted = 1'b1;
    end
    reset = 1'b0;
  endtask

  logic [5:0] rfuncts [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
  logic [5:0] lops    [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

  initial begin
    reset = 1'b1;
    op    = 6'd0;
    funct = 6'd0;
    zero  = 1'b0;
    @(posedge clk);
    #1;
    repeat (2) begin
      @(negedge clk);
      check_dut(0, 0, 1'b1);
      check_dut(1, 0, 1'b1);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;

    run_instr(6'b100011, 6'd0, 2, 3);
    run_instr(6'b100011, 6'd0, 2, -1);
    run_instr(6'b000100, 6'd0, 1, -1);
    run_instr(6'b000100, 6'd0, 0, -1);
    for (int i = 0; i < 6; i++) run_instr(6'b000000, rfuncts[i], 2, -1);
    run_instr(6'b101011, 6'd0, 2, -1);
    run_instr(6'b001000, 6'd0, 2, -1);
    run_instr(6'b000010, 6'd0, 2, -1);
    run_instr(6'b111111, 6'd0, 2, -1);
    repeat (4) run_instr(6'b100011, 6'd0, 2, -1);
    run_instr(6'b000010, 6'd0, 2, 0);
    run_instr(6'b001000, 6'd0, 2, -1);

    repeat (300) begin
      logic [5:0] o;
      logic [5:0] fn;
      int rst_at;
      int k;
      k = $urandom_range(0, 7);
      if (k < 6) begin
        o = lops[k];
      end else begin
        do o = 6'($urandom_range(0, 63)); while (is_legal(o));
      end
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : rfuncts[$urandom_range(0, 5)];
      rst_at = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1;
      run_instr(o, fn, 2, rst_at);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
